fifo_wr_arb: RTL and testbench
==============================

# fifo_wr_arb

Round-robin write-port arbiter that shares one `fifo_async` write port among `NREQ` requesters in the write-clock domain. Each requester presents a beat stream; the arbiter grants one requester at a time for a bounded burst, registers the selected beat onto `w_en`/`wdata`, and holds it while `w_full` is asserted. New grants are withheld while the FIFO fill level (`wuse`) is at or above an almost-full threshold, so no beat is ever dropped.

## Interface
Parameters:
- `NREQ`, 4: number of requesters (2..8)
- `DSIZE`, 8: data width, equal to the FIFO `DSIZE`
- `ASIZE`, 5: FIFO address width, equal to the FIFO `ASIZE`
- `BURST`, 4: maximum beats per grant (1..16)
- `AF_LEVEL`, 28: no new grant while `wuse >= AF_LEVEL`; must be < 2^ASIZE

Ports:
- `wclk` in 1: write clock; the only clock
- `rst` in 1: synchronous reset, active-high
- `req` in NREQ: requester i has a valid beat
- `req_data` in NREQ*DSIZE: requester i data at `[i*DSIZE +: DSIZE]`
- `req_last` in NREQ: the current beat of requester i ends its burst
- `ack` out NREQ: beat of requester i consumed this cycle; combinational, at most one bit set
- `gnt_valid` out 1: a grant is active (registered)
- `cur_gnt` out $clog2(NREQ): index of the granted requester (registered)
- `w_en` out 1: FIFO write enable (registered)
- `wdata` out DSIZE: FIFO write data (registered)
- `w_full` in 1: FIFO full, from `fifo_async`
- `wuse` in ASIZE: FIFO write-domain used count, from `fifo_async`

## Operation
- Two-state FSM: IDLE and GRANT. Registered state: round-robin pointer `ptr`, burst counter `cnt`, output beat register (`w_en`, `wdata`).
- Output register ready: `ob_ready = !w_en || !w_full`.
- Accept: `ack[i] = (state==GRANT) && cur_gnt==i && req[i] && ob_ready`. On an accept, `w_en <= 1` and `wdata <= req_data[i]`.
- If there is no accept: `w_en && !w_full` clears `w_en` (the beat was written); `w_en && w_full` holds `w_en` and `wdata` unchanged.
- IDLE: if `|req` and `wuse < AF_LEVEL`, grant the first requesting index at or after `ptr` (scanning upward modulo NREQ). Set `cur_gnt`, `gnt_valid <= 1`, `cnt <= 0`, and go to GRANT. Otherwise stay in IDLE.
- GRANT: each accept increments `cnt`. Return to IDLE with `gnt_valid <= 0` and `ptr <= (cur_gnt+1) mod NREQ` in any of these cases:
  - the accept carries `req_last[cur_gnt]`;
  - the accept occurs with `cnt == BURST-1`;
  - `req[cur_gnt] == 0` (requester withdrew; no accept occurs that cycle).
- Almost-full gates only the IDLE→GRANT transition. A burst in progress continues; only `w_full` stalls it.
- Inputs `req`, `req_last` and `req_data` of non-granted requesters are ignored. A requester must hold `req_data` stable until its `ack`.

## Timing
- Reset values: state IDLE, `ptr=0`, `cnt=0`, `gnt_valid=0`, `cur_gnt=0`, `w_en=0`, `wdata=0`. `ack=0` follows combinationally.
- Latency: `req` seen in IDLE at edge n gives `gnt_valid=1` after edge n; first `ack` in that same cycle (if `ob_ready`); `w_en=1` after edge n+1.
- Sustained throughput is 1 beat/cycle within a burst. There is exactly one idle cycle between bursts (GRANT→IDLE→GRANT).
- A FIFO write occurs at an edge where `w_en && !w_full`. With `w_full` high, the held beat is written on the first edge where `w_full` is low, and an accept may occur in that same cycle.
- Boundary cases:
  - `wuse == AF_LEVEL-1` allows a grant; `wuse == AF_LEVEL` blocks it.
  - `ptr` wraps from NREQ-1 to 0.
  - `req_last` on the BURST-th beat ends the burst once, not twice.
  - `BURST=1` gives single-beat grants.
- Reset asserted mid-burst: all state returns to reset values on that edge. A pending held beat is discarded and not written.

## Test plan
- Single requester, 0: `req[0]=1` continuously, data 0x10..0x17, `w_full=0`, `wuse=0`. Expect `w_en` carrying 0x10–0x13, one idle cycle, then 0x14–0x17; `cur_gnt=0` throughout.
- All four requesting continuously (NREQ=4, BURST=4). Expect grant order 0,1,2,3,0, each burst 4 beats, one-cycle gap between bursts, `ack` one-hot.
- Stall: during a burst, force `w_full=1` for 3 cycles. Expect `w_en=1` and `wdata` frozen, `ack=0` during the stall. On release, the held beat is written and the next beat is accepted in the same cycle; no loss or duplication versus the data sent.
- Almost-full: `wuse=28` with `req[2]=1`. Expect `gnt_valid=0` indefinitely. Drop `wuse` to 27: grant to 2 on the next edge.
- Early end and withdrawal: requester 1 asserts `req_last` on its 2nd beat, so the grant ends after 2 beats and `ptr=2`. Requester 3 deasserts `req` mid-burst, so GRANT exits with no accept that cycle.
- Reset mid-burst with `w_full=1` and a held beat. Expect all outputs at reset values next cycle, and the held beat never written.

Source files
------------

// File: rtl/fifo_wr_arb_if.sv
// Requester / FIFO write-port bundle for fifo_wr_arb.
// mst is the arbiter side, slv the requester/FIFO side.
interface fifo_wr_arb_if #(
  parameter int NREQ  = 4,
  parameter int DSIZE = 8,
  parameter int ASIZE = 5
);
  localparam int GW = $clog2(NREQ);

  logic [NREQ-1:0]       req;
  logic [NREQ*DSIZE-1:0] req_data;
  logic [NREQ-1:0]       req_last;
  logic [NREQ-1:0]       ack;
  logic                  gnt_valid;
  logic [GW-1:0]         cur_gnt;
  logic                  w_en;
  logic [DSIZE-1:0]      wdata;
  logic                  w_full;
  logic [ASIZE-1:0]      wuse;

  modport mst (
    input  req, req_data, req_last,
    input  w_full, wuse,
    output ack, gnt_valid, cur_gnt,
    output w_en, wdata
  );

  modport slv (
    output req, req_data, req_last,
    output w_full, wuse,
    input  ack, gnt_valid, cur_gnt,
    input  w_en, wdata
  );
endinterface

// File: rtl/fifo_wr_arb.sv
// Round-robin burst arbiter sharing one FIFO write port.
// One registered beat stage absorbs w_full stalls losslessly.
module fifo_wr_arb #(
  parameter int NREQ     = 4,
  parameter int DSIZE    = 8,
  parameter int ASIZE    = 5,
  parameter int BURST    = 4,
  parameter int AF_LEVEL = 28
) (
  input  logic       wclk,
  input  logic       rst,
  fifo_wr_arb_if.mst bus
);
  localparam int GW = $clog2(NREQ);
  localparam int CW = 5;
  localparam logic [CW-1:0] LAST_CNT = CW'(BURST - 1);
  localparam logic [GW-1:0] TOP_IDX = GW'(NREQ - 1);

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_t;

  state_t           r_state;
  state_t           w_state_n;
  logic [GW-1:0]    r_ptr;
  logic [GW-1:0]    w_ptr_n;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_n;
  logic [GW-1:0]    r_gnt;
  logic [GW-1:0]    w_gnt_n;
  logic             r_gv;
  logic             w_gv_n;
  logic             r_wen;
  logic [DSIZE-1:0] r_wdata;

  logic             w_ob_ready;
  logic             w_sel_req;
  logic             w_sel_last;
  logic [DSIZE-1:0] w_sel_data;
  logic             w_accept;
  logic             w_room;
  logic [GW-1:0]    w_pick;
  logic [NREQ-1:0]  w_ack;

  // First requesting index at or after p, scanning upward mod NREQ.
  function automatic logic [GW-1:0] rr_pick(
    input logic [NREQ-1:0] r,
    input logic [GW-1:0]   p
  );
    logic [GW-1:0] pick;
    logic [GW-1:0] jj;
    int            j;
    pick = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = int'(p) + k;
      if (j >= NREQ) j = j - NREQ;
      jj = GW'(j);
      if (r[jj]) pick = jj;
    end
    return pick;
  endfunction

  assign w_ob_ready = !r_wen || !bus.w_full;
  assign w_sel_req  = bus.req[r_gnt];
  assign w_sel_last = bus.req_last[r_gnt];
  assign w_sel_data = bus.req_data[r_gnt*DSIZE +: DSIZE];
  assign w_accept   = (r_state == S_GRANT) && w_sel_req && w_ob_ready;
  assign w_room     = bus.wuse < ASIZE'(AF_LEVEL);
  assign w_pick     = rr_pick(bus.req, r_ptr);

  always_comb begin
    w_ack = '0;
    if (w_accept) w_ack[r_gnt] = 1'b1;
  end

  always_comb begin
    w_state_n = r_state;
    w_ptr_n   = r_ptr;
    w_cnt_n   = r_cnt;
    w_gnt_n   = r_gnt;
    w_gv_n    = r_gv;
    unique case (r_state)
      S_IDLE: begin
        if (|bus.req && w_room) begin
          w_gnt_n   = w_pick;
          w_gv_n    = 1'b1;
          w_cnt_n   = '0;
          w_state_n = S_GRANT;
        end
      end
      S_GRANT: begin
        if (w_accept) w_cnt_n = r_cnt + 1'b1;
        // Withdrawal, last beat or full burst all release the grant.
        if (!w_sel_req ||
            (w_accept && (w_sel_last || r_cnt == LAST_CNT))) begin
          w_state_n = S_IDLE;
          w_gv_n    = 1'b0;
          w_ptr_n   = (r_gnt == TOP_IDX) ? '0 : r_gnt + 1'b1;
        end
      end
      default: begin
        w_state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge wclk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_gnt   <= '0;
      r_gv    <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_ptr   <= w_ptr_n;
      r_cnt   <= w_cnt_n;
      r_gnt   <= w_gnt_n;
      r_gv    <= w_gv_n;
    end
  end

  // A held beat stays put while w_full; reset drops it unwritten.
  always_ff @(posedge wclk) begin
    if (rst) begin
      r_wen   <= 1'b0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_wen   <= 1'b1;
      r_wdata <= w_sel_data;
    end else if (r_wen && !bus.w_full) begin
      r_wen   <= 1'b0;
    end
  end

  assign bus.ack       = w_ack;
  assign bus.gnt_valid = r_gv;
  assign bus.cur_gnt   = r_gnt;
  assign bus.w_en      = r_wen;
  assign bus.wdata     = r_wdata;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Scoreboard bench for fifo_wr_arb: expected FIFO writes and
// grant order are queued with the stimulus, checked on output.
module tb_fifo_wr_arb;
  localparam int NREQ  = 4;
  localparam int DSIZE = 8;
  localparam int ASIZE = 5;
  localparam int BURST = 4;
  localparam int AF    = 28;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } beat_t;

  typedef struct {
    logic [7:0] data;
    int         gap;
  } exp_t;

  logic wclk = 1'b0;
  logic rst  = 1'b1;

  fifo_wr_arb_if #(
    .NREQ(NREQ), .DSIZE(DSIZE), .ASIZE(ASIZE)
  ) bus ();

  fifo_wr_arb #(
    .NREQ(NREQ), .DSIZE(DSIZE), .ASIZE(ASIZE),
    .BURST(BURST), .AF_LEVEL(AF)
  ) dut (
    .wclk(wclk),
    .rst (rst),
    .bus (bus)
  );

  always #5 wclk = ~wclk;

  beat_t           src[NREQ][$];
  exp_t            exp_q[$];
  int              exp_gnt[$];
  int              n_chk = 0;
  int              n_err = 0;
  int              cyc = 0;
  int              last_w = 0;
  logic            prev_gv = 1'b0;
  logic [NREQ-1:0] r_ack = '0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cyc %0d)",
               tag, obs, exp, cyc);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      bus.req[i] = src[i].size() != 0;
      if (src[i].size() != 0) begin
        bus.req_data[i*DSIZE +: DSIZE] = src[i][0].data;
        bus.req_last[i] = src[i][0].last;
      end else begin
        bus.req_data[i*DSIZE +: DSIZE] = '0;
        bus.req_last[i] = 1'b0;
      end
    end
  endtask

  task automatic add(input int r, input int d, input logic l);
    beat_t b;
    b.last = l;
    b.data = 8'(d);
    src[r].push_back(b);
  endtask

  task automatic expw(input int d, input int gap);
    exp_t e;
    e.data = 8'(d);
    e.gap  = gap;
    exp_q.push_back(e);
  endtask

  task automatic step();
    exp_t e;
    @(negedge wclk);
    r_ack = bus.ack;
    chk("ack1h", 32'($countones(bus.ack) <= 1), 32'd1);
    if (bus.gnt_valid && !prev_gv) begin
      if (exp_gnt.size() == 0)
        chk("gnt_extra", 32'(exp_gnt.size()), 32'd1);
      else
        chk("gnt", 32'(bus.cur_gnt), 32'(exp_gnt.pop_front()));
    end
    prev_gv = bus.gnt_valid;
    if (bus.w_en && !bus.w_full) begin
      if (exp_q.size() == 0) begin
        chk("wr_extra", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk("wdata", 32'(bus.wdata), 32'(e.data));
        if (e.gap != 0) chk("gap", 32'(cyc - last_w), 32'(e.gap));
      end
      last_w = cyc;
    end
    @(posedge wclk);
    cyc++;
    #1;
    for (int i = 0; i < NREQ; i++)
      if (r_ack[i] && src[i].size() != 0) void'(src[i].pop_front());
    drive();
  endtask

  function automatic logic drained();
    logic d;
    d = exp_q.size() == 0 && exp_gnt.size() == 0;
    for (int i = 0; i < NREQ; i++)
      if (src[i].size() != 0) d = 1'b0;
    return d && !bus.w_en && !bus.gnt_valid;
  endfunction

  task automatic drain(input int budget);
    logic done;
    done = drained();
    for (int n = 0; n < budget && !done; n++) begin
      step();
      done = drained();
    end
    chk("drain", 32'(done), 32'd1);
  endtask

  task automatic do_reset();
    for (int i = 0; i < NREQ; i++) src[i].delete();
    bus.w_full = 1'b0;
    bus.wuse   = '0;
    rst = 1'b1;
    drive();
    step();
    rst = 1'b0;
  endtask

  initial begin
    bus.w_full = 1'b0;
    bus.wuse   = '0;
    drive();
    do_reset();
    chk("rst_gv", 32'(bus.gnt_valid), 32'd0);
    chk("rst_gnt", 32'(bus.cur_gnt), 32'd0);
    chk("rst_wen", 32'(bus.w_en), 32'd0);
    chk("rst_wdata", 32'(bus.wdata), 32'd0);
    chk("rst_ack", 32'(bus.ack), 32'd0);

    // single requester, two bursts of four
    for (int j = 0; j < 8; j++) begin
      add(0, 16 + j, 1'b0);
      expw(16 + j, j == 0 ? 0 : (j == 4 ? 2 : 1));
    end
    exp_gnt.push_back(0);
    exp_gnt.push_back(0);
    drive();
    drain(40);

    // all four requesting: 0,1,2,3,0
    do_reset();
    for (int j = 0; j < 8; j++) add(0, j, 1'b0);
    for (int i = 1; i < NREQ; i++)
      for (int j = 0; j < 4; j++)
        add(i, i*32 + j, (i == 2 && j == 3));
    for (int b = 0; b < 5; b++) begin
      for (int j = 0; j < 4; j++)
        expw(b == 4 ? 4 + j : b*32 + j,
             j != 0 ? 1 : (b == 0 ? 0 : 2));
      exp_gnt.push_back(b % NREQ);
    end
    drive();
    drain(60);

    // w_full stall mid-burst
    do_reset();
    for (int j = 0; j < 4; j++) add(0, 8'hA0 + j, 1'b0);
    expw(8'hA0, 0);
    expw(8'hA1, 4);
    expw(8'hA2, 1);
    expw(8'hA3, 1);
    exp_gnt.push_back(0);
    drive();
    step();
    step();
    step();
    bus.w_full = 1'b1;
    for (int s = 0; s < 3; s++) begin
      #1;
      chk("stall_ack", 32'(bus.ack), 32'd0);
      chk("stall_wen", 32'(bus.w_en), 32'd1);
      chk("stall_wdata", 32'(bus.wdata), 32'hA1);
      step();
    end
    bus.w_full = 1'b0;
    drain(30);

    // almost-full gating
    do_reset();
    bus.wuse = 5'(AF);
    add(2, 8'hB0, 1'b0);
    add(2, 8'hB1, 1'b0);
    expw(8'hB0, 0);
    expw(8'hB1, 1);
    exp_gnt.push_back(2);
    drive();
    for (int s = 0; s < 6; s++) begin
      step();
      chk("af_gv", 32'(bus.gnt_valid), 32'd0);
    end
    bus.wuse = 5'(AF - 1);
    step();
    chk("af_gv_rel", 32'(bus.gnt_valid), 32'd1);
    chk("af_gnt", 32'(bus.cur_gnt), 32'd2);
    drain(30);

    // early req_last on 1, withdrawal on 3
    do_reset();
    add(1, 8'hC0, 1'b0);
    add(1, 8'hC1, 1'b1);
    add(1, 8'hC2, 1'b0);
    add(1, 8'hC3, 1'b0);
    add(3, 8'hD0, 1'b0);
    add(3, 8'hD1, 1'b0);
    expw(8'hC0, 0);
    expw(8'hC1, 1);
    expw(8'hD0, 2);
    expw(8'hD1, 1);
    expw(8'hC2, 3);
    expw(8'hC3, 1);
    exp_gnt.push_back(1);
    exp_gnt.push_back(3);
    exp_gnt.push_back(1);
    drive();
    drain(40);

    // reset mid-burst with a held beat
    do_reset();
    for (int j = 0; j < 4; j++) add(2, 8'hE0 + j, 1'b0);
    exp_gnt.push_back(2);
    drive();
    step();
    step();
    bus.w_full = 1'b1;
    #1;
    chk("hold_wen", 32'(bus.w_en), 32'd1);
    chk("hold_wdata", 32'(bus.wdata), 32'hE0);
    rst = 1'b1;
    src[2].delete();
    drive();
    step();
    rst = 1'b0;
    bus.w_full = 1'b0;
    #1;
    chk("mrst_gv", 32'(bus.gnt_valid), 32'd0);
    chk("mrst_gnt", 32'(bus.cur_gnt), 32'd0);
    chk("mrst_wen", 32'(bus.w_en), 32'd0);
    chk("mrst_wdata", 32'(bus.wdata), 32'd0);
    chk("mrst_ack", 32'(bus.ack), 32'd0);
    drain(10);
    for (int s = 0; s < 4; s++) step();
    chk("exp_left", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end
endmodule
